// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline with memory-wait FSM.
// Optional cycle counters when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int         MEM_TIMEOUT = 16,
  parameter logic [4:0] RA_REG      = 5'd31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic       branch_d,
  input  logic       jr_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] writereg_e,
  input  logic [4:0] writereg_m,
  input  logic [4:0] writereg_w,
  input  logic       regwrite_e,
  input  logic       regwrite_m,
  input  logic       regwrite_w,
  input  logic       memtoreg_e,
  input  logic       memtoreg_m,
  input  logic       jal_e,
  input  logic       memreq_m,
  input  logic       memready_m,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_e,
  output logic       flush_w,
  output logic       forward_a_d,
  output logic       forward_b_d,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       mem_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] lwstall_cnt,
  output logic [31:0] brstall_cnt,
  output logic [31:0] memwait_cnt
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN, MEMWAIT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          err_q, err_n;

  logic [4:0] dst_e;
  logic       lwstall, br_e, br_m, brstall, hz, memhold;

  assign dst_e   = jal_e ? RA_REG : writereg_e;
  assign lwstall = memtoreg_e && dst_e != 5'd0
                && (dst_e == rs_d || dst_e == rt_d);
  assign br_e    = regwrite_e && dst_e != 5'd0
                && (dst_e == rs_d || (branch_d && dst_e == rt_d));
  assign br_m    = memtoreg_m && writereg_m != 5'd0
                && (writereg_m == rs_d
                    || (branch_d && writereg_m == rt_d));
  assign brstall = (branch_d || jr_d) && (br_e || br_m);
  assign hz      = lwstall || brstall;
  // In MEMWAIT the request is already latched; only ready releases it.
  assign memhold = (state == MEMWAIT) ? !memready_m
                                      : (memreq_m && !memready_m);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = err_q;
    unique case (state)
      RUN: begin
        if (memhold) begin
          state_n = MEMWAIT;
          cnt_n   = CW'(1);
        end
      end
      MEMWAIT: begin
        if (memready_m) begin
          state_n = RUN;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = RUN;
          cnt_n   = '0;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = RUN;
        cnt_n   = '0;
      end
    endcase
  end

  function automatic logic [1:0] fwd_e(input logic [4:0] src);
    logic [1:0] f;
    f = 2'b00;
    priority case (1'b1)
      (src != 5'd0 && regwrite_m && writereg_m == src): f = 2'b10;
      (src != 5'd0 && regwrite_w && writereg_w == src): f = 2'b01;
      default: f = 2'b00;
    endcase
    return f;
  endfunction

  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    forward_a_d = 1'b0;
    forward_b_d = 1'b0;
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    mem_err     = 1'b0;
    if (reset) begin
      flush_e = 1'b1;
    end else begin
      if (memhold) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else begin
        stall_f = hz;
        stall_d = hz;
        flush_e = hz;
      end
      forward_a_d = rs_d != 5'd0 && regwrite_m && writereg_m == rs_d;
      forward_b_d = rt_d != 5'd0 && regwrite_m && writereg_m == rt_d;
      forward_a_e = fwd_e(rs_e);
      forward_b_e = fwd_e(rt_e);
      mem_err     = err_q;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lwstall_cnt <= '0;
      brstall_cnt <= '0;
      memwait_cnt <= '0;
    end else begin
      if (!memhold && lwstall && lwstall_cnt != '1)
        lwstall_cnt <= lwstall_cnt + 32'd1;
      if (!memhold && brstall && brstall_cnt != '1)
        brstall_cnt <= brstall_cnt + 32'd1;
      if (memhold && memwait_cnt != '1)
        memwait_cnt <= memwait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed plan steps plus random traffic
// checked against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic [4:0] writereg_e, writereg_m, writereg_w;
  logic       branch_d, jr_d;
  logic       regwrite_e, regwrite_m, regwrite_w;
  logic       memtoreg_e, memtoreg_m, jal_e;
  logic       memreq_m, memready_m;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_e, flush_w, forward_a_d, forward_b_d;
  logic [1:0] forward_a_e, forward_b_e;
  logic       mem_err;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] lwstall_cnt, brstall_cnt, memwait_cnt;
  logic [31:0] m_lw, m_br, m_mw;
`endif

  int checks = 0;
  int errors = 0;

  bit m_wait = 1'b0;
  int m_streak = 0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .RA_REG(5'd31)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d),
    .branch_d(branch_d), .jr_d(jr_d),
    .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m),
    .writereg_w(writereg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
    .jal_e(jal_e),
    .memreq_m(memreq_m), .memready_m(memready_m),
    .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m),
    .flush_e(flush_e), .flush_w(flush_w),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .mem_err(mem_err)
`ifdef HAZ_PERF_CNT_EN
    ,
    .lwstall_cnt(lwstall_cnt), .brstall_cnt(brstall_cnt),
    .memwait_cnt(memwait_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A source register is "hit" by a nonzero destination it names.
  function automatic bit hit(int dst, int a, int b, bit use_b);
    return dst != 0 && (dst == a || (use_b && dst == b));
  endfunction

  function automatic logic [1:0] ref_fwd(int src);
    if (src == 0) return 2'b00;
    if (regwrite_m && writereg_m == src) return 2'b10;
    if (regwrite_w && writereg_w == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clr();
    {rs_d, rt_d, rs_e, rt_e} = '0;
    {writereg_e, writereg_m, writereg_w} = '0;
    {branch_d, jr_d, regwrite_e, regwrite_m, regwrite_w} = '0;
    {memtoreg_e, memtoreg_m, jal_e, memreq_m, memready_m} = '0;
  endtask

  // Check every output for the current cycle, then advance one clock
  // and update the model with the inputs that were sampled.
  task automatic step();
    int  dst;
    bit  lw, br, hz, hold;
    logic [10:0] e;
    dst  = jal_e ? 31 : writereg_e;
    lw   = memtoreg_e && hit(dst, rs_d, rt_d, 1'b1);
    br   = (branch_d || jr_d) &&
           ((regwrite_e && hit(dst, rs_d, rt_d, branch_d)) ||
            (memtoreg_m && hit(writereg_m, rs_d, rt_d, branch_d)));
    hz   = lw || br;
    hold = m_wait ? !memready_m : (memreq_m && !memready_m);
    #1;
    if (reset) begin
      chk("rst_flush_e", flush_e, 1);
      chk("rst_others", {stall_f, stall_d, stall_e, stall_m, flush_w,
          forward_a_d, forward_b_d, forward_a_e, forward_b_e,
          mem_err}, 0);
    end else begin
      chk("stall_f", stall_f, hold | hz);
      chk("stall_d", stall_d, hold | hz);
      chk("stall_e", stall_e, hold);
      chk("stall_m", stall_m, hold);
      chk("flush_w", flush_w, hold);
      chk("flush_e", flush_e, !hold && hz);
      chk("forward_a_d", forward_a_d,
          rs_d != 0 && regwrite_m && writereg_m == rs_d);
      chk("forward_b_d", forward_b_d,
          rt_d != 0 && regwrite_m && writereg_m == rt_d);
      chk("forward_a_e", forward_a_e, ref_fwd(rs_e));
      chk("forward_b_e", forward_b_e, ref_fwd(rt_e));
      chk("mem_err", mem_err, m_err);
    end
`ifdef HAZ_PERF_CNT_EN
    chk("lwstall_cnt", lwstall_cnt, m_lw);
    chk("brstall_cnt", brstall_cnt, m_br);
    chk("memwait_cnt", memwait_cnt, m_mw);
`endif
    @(posedge clk);
    if (reset) begin
      m_wait = 0; m_streak = 0; m_err = 0;
`ifdef HAZ_PERF_CNT_EN
      m_lw = 0; m_br = 0; m_mw = 0;
`endif
    end else begin
`ifdef HAZ_PERF_CNT_EN
      if (!hold && lw && m_lw != '1) m_lw++;
      if (!hold && br && m_br != '1) m_br++;
      if (hold && m_mw != '1) m_mw++;
`endif
      if (hold) begin
        m_streak++;
        if (m_streak == TMO) begin
          m_err = 1; m_wait = 0; m_streak = 0;
        end else begin
          m_wait = 1;
        end
      end else begin
        m_wait = 0; m_streak = 0;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick();
    return ($urandom_range(0, 7) == 0) ? 5'd31
                                       : 5'($urandom_range(0, 3));
  endfunction

  initial begin
    clr();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    // Forwarding: M beats W, register 0 never forwards.
    regwrite_m = 1; writereg_m = 8; regwrite_w = 1; writereg_w = 8;
    rs_e = 8; rt_e = 9;
    #1 chk("plan_fwd_a_m", forward_a_e, 2'b10);
    chk("plan_fwd_b_none", forward_b_e, 2'b00);
    step();
    rs_e = 0; writereg_m = 0;
    step();
    clr();

    // Load-use for one cycle, then clear.
    memtoreg_e = 1; writereg_e = 5; rt_d = 5;
    #1 chk("plan_lw_stall", {stall_f, stall_d, flush_e}, 3'b111);
    step();
    memtoreg_e = 0;
    step();
    clr();

    // Branch on E result, then forward from M.
    branch_d = 1; rs_d = 3; regwrite_e = 1; writereg_e = 3;
    #1 chk("plan_br_stall", stall_d, 1);
    step();
    regwrite_e = 0; regwrite_m = 1; writereg_m = 3;
    #1 chk("plan_br_fwd", {forward_a_d, stall_d}, 2'b10);
    step();
    clr();

    // jal writes ra in E, jr reads it in D.
    jal_e = 1; regwrite_e = 1; jr_d = 1; rs_d = 31;
    #1 chk("plan_jal_stall", stall_d, 1);
    step();
    clr();

    // Three-cycle memory wait, released on the fourth.
    memreq_m = 1; memready_m = 0;
    repeat (3) step();
    memready_m = 1;
    #1 chk("plan_mem_release", stall_m, 0);
    step();
    clr();
    step();

    // Timeout, with load-use pending during the wait.
    memreq_m = 1; memtoreg_e = 1; writereg_e = 7; rs_d = 7;
    repeat (TMO) step();
    clr();
    #1 chk("plan_mem_err", mem_err, 1);
    repeat (3) step();
    chk("plan_mem_err_sticky", mem_err, 1);

    // Reset during the second wait cycle.
    memreq_m = 1;
    step();
    step();
    reset = 1;
    step();
    reset = 0; memreq_m = 0;
    #1 chk("plan_rst_clear", {stall_m, flush_w, mem_err}, 0);
    step();

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      rs_d = pick(); rt_d = pick(); rs_e = pick(); rt_e = pick();
      writereg_e = pick(); writereg_m = pick(); writereg_w = pick();
      branch_d = ($urandom_range(0, 2) == 0);
      jr_d = !branch_d && ($urandom_range(0, 3) == 0);
      regwrite_e = $urandom_range(0, 1);
      regwrite_m = $urandom_range(0, 1);
      regwrite_w = $urandom_range(0, 1);
      memtoreg_e = $urandom_range(0, 1);
      memtoreg_m = $urandom_range(0, 1);
      jal_e = ($urandom_range(0, 5) == 0);
      memreq_m = ($urandom_range(0, 2) == 0);
      memready_m = ($urandom_range(0, 9) < 3);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Consumes the execute-stage outputs of the decode/execute pipeline register (rs_e, rt_e, regwrite_e, memtoreg_e, jal_e), plus memory and writeback destination info.
- Drives flush_e and the stall and forward controls back into that register and the surrounding stages.
- Adds a sequential wait FSM for a multi-cycle data memory and a bounded branch-resolve stall.

Parameters:
- MEM_TIMEOUT, 16: max cycles in MEMWAIT before mem_err asserts.
- RA_REG, 31: destination register number written by jal in execute.

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- rs_d, rt_d  in  5  decode source registers.
- branch_d, jr_d  in  1  decode branch / jump-register.
- rs_e, rt_e  in  5  execute source registers (from D/E register).
- writereg_e, writereg_m, writereg_w  in  5  destination register per stage.
- regwrite_e, regwrite_m, regwrite_w  in  1  write enables per stage.
- memtoreg_e, memtoreg_m  in  1  load in E / M.
- jal_e  in  1  jal in execute (dest = RA_REG).
- memreq_m  in  1  M stage accessing data memory.
- memready_m  in  1  data memory completes access this cycle.
- stall_f, stall_d, stall_e, stall_m  out  1  hold stage registers.
- flush_e  out  1  bubble into the D/E register.
- flush_w  out  1  bubble into the M/W register.
- forward_a_d, forward_b_d  out  1  decode compare forward from M.
- forward_a_e, forward_b_e  out  2  00 = regfile, 10 = M result, 01 = W result.
- mem_err  out  1  memory timeout, sticky until reset.

Behaviour:
- FSM states: RUN, MEMWAIT. Reset, synchronous: state=RUN, wait counter=0, mem_err=0.
- Outputs are combinational from state and inputs. While reset=1, all outputs are forced to 0 except flush_e=1.
- Execute forwarding, A path (B path identical with rt_e):
  - rs_e!=0 && regwrite_m && writereg_m==rs_e → 10.
  - Else rs_e!=0 && regwrite_w && writereg_w==rs_e → 01.
  - Else 00.
  - M has priority over W.
- Decode forwarding: forward_a_d = rs_d!=0 && regwrite_m && writereg_m==rs_d (B path with rt_d).
- Effective execute destination: dst_e = jal_e ? RA_REG : writereg_e.
- lwstall = memtoreg_e && (dst_e==rs_d || dst_e==rt_d), ignoring register 0.
- brstall = (branch_d || jr_d) && either of:
  - regwrite_e && dst_e matches a nonzero rs_d/rt_d (jr_d uses rs_d only);
  - memtoreg_m && writereg_m matches a nonzero rs_d/rt_d.
- RUN state:
  - hz = lwstall || brstall; stall_f = stall_d = flush_e = hz.
  - If memreq_m && !memready_m: go to MEMWAIT, and this cycle stall_f/d/e/m=1, flush_w=1, flush_e=0.
- MEMWAIT state:
  - stall_f/d/e/m=1, flush_w=1, flush_e=0; hazard stalls are suppressed (pipeline frozen).
  - Counter increments each cycle.
  - memready_m=1 → outputs as in RUN with memory released this cycle (stall_e/m=0, flush_w=0); next state RUN, counter cleared.
  - Counter reaching MEMTIMEOUT-1 without ready → mem_err=1, next state RUN, counter cleared.
- A zero-latency memory (memready_m=1 with memreq_m) never leaves RUN.
- Simultaneous load-use and memory wait: the memory wait wins. The load-use stall re-evaluates after release.
- Reset mid-MEMWAIT → RUN next cycle, counter and mem_err cleared.

Optional Feature:
- Macro HAZ_PERF_CNT_EN. When defined, adds outputs lwstall_cnt[31:0], brstall_cnt[31:0], memwait_cnt[31:0].
- Each counts cycles its condition drove a stall; counters saturate at all-ones and clear on reset.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Forwarding: regwrite_m=1, writereg_m=8, regwrite_w=1, writereg_w=8, rs_e=8, rt_e=9 → forward_a_e=10, forward_b_e=00. Then rs_e=0 with writereg_m=0 → 00.
- Load-use: memtoreg_e=1, writereg_e=5, rt_d=5 → stall_f=stall_d=flush_e=1 for one cycle. Next cycle memtoreg_e=0 → all 0.
- Branch: branch_d=1, rs_d=3, regwrite_e=1, writereg_e=3 → stall one cycle. Next cycle value in M → forward_a_d=1, no stall.
- jal: jal_e=1, writereg_e=0, jr_d=1, rs_d=31, regwrite_e=1 → stall_d=1.
- Memory wait: memreq_m=1, memready_m=0 for 3 cycles then 1 → stall_m=flush_w=1 for 3 cycles; cycle 4 stall_m=0, state RUN. Repeat with 16 cycles no ready → mem_err=1 sticky.
- Reset asserted during MEMWAIT cycle 2 → next cycle all stalls 0, mem_err=0; flush_e=1 while reset held.
